// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt acknowledge path.
// Fixed priority: IR0 is the highest level.
package pic_pkg;

  localparam int unsigned NumLevels = 8;
  localparam int unsigned LevelW = 3;
  localparam logic [LevelW-1:0] SpuriousLevel = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait2,
    StAck2
  } picState_e;

  // Index of the highest-priority (lowest-numbered) set bit; 0 when vec is empty.
  function automatic logic [LevelW-1:0] highestPri(input logic [NumLevels-1:0] vec);
    logic [LevelW-1:0] idx;
    idx = '0;
    for (int i = int'(NumLevels) - 1; i >= 0; i--) begin
      if (vec[i]) idx = LevelW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fully nested priority resolver: picks the best pending request that strictly
// outranks every level currently in service.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NumLevels-1:0] irqPending,
  input  logic [NumLevels-1:0] isr,
  output logic                 candValid,
  output logic [LevelW-1:0]    candLevel
);

  logic [LevelW-1:0]    isrTop;
  logic [NumLevels-1:0] priMask;
  logic [NumLevels-1:0] eligible;

  always_comb begin
    isrTop  = highestPri(isr);
    priMask = '0;
    for (int i = 0; i < int'(NumLevels); i++) begin
      // An empty ISR lets every level through.
      priMask[i] = (isr == '0) || (LevelW'(i) < isrTop);
    end
    eligible  = irqPending & priMask;
    candValid = |eligible;
    candLevel = highestPri(eligible);
  end

endmodule

// File: rtl/pic_inta_sequencer.sv
// CPU-side request/acknowledge sequencer: raises INT, runs the two-pulse INTA
// handshake, owns the ISR and drives the vector byte onto the data bus.
module pic_inta_sequencer
  import pic_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NumLevels-1:0] irqPending,
  input  logic                 intaN,
  input  logic [4:0]           vectorBase,
  input  logic                 aeoiMode,
  input  logic                 eoiValid,
  input  logic                 eoiSpecific,
  input  logic [LevelW-1:0]    eoiLevel,
  output logic                 intOut,
  output logic                 clearIRR,
  output logic [LevelW-1:0]    resetIRR,
  output logic [NumLevels-1:0] isr,
  output logic [7:0]           dataOut,
  output logic                 dataOutEn
);

  picState_e            state;
  logic                 intaNQ;
  logic [LevelW-1:0]    levelQ;
  logic                 spuriousQ;

  logic                 candValid;
  logic [LevelW-1:0]    candLevel;
  logic                 fall;
  logic                 rise;
  logic [NumLevels-1:0] setMask;
  logic [NumLevels-1:0] eoiMask;
  logic [NumLevels-1:0] aeoiMask;
  logic [NumLevels-1:0] isrNext;

  pic_priority_resolver uResolver (
    .irqPending (irqPending),
    .isr        (isr),
    .candValid  (candValid),
    .candLevel  (candLevel)
  );

  always_comb begin
    fall     = intaNQ & ~intaN;
    rise     = ~intaNQ & intaN;
    setMask  = '0;
    eoiMask  = '0;
    aeoiMask = '0;
    if (state == StReq && fall && candValid) setMask[candLevel] = 1'b1;
    if (state == StAck2 && rise && aeoiMode && !spuriousQ) aeoiMask[levelQ] = 1'b1;
    if (eoiValid) begin
      if (eoiSpecific) eoiMask[eoiLevel] = 1'b1;
      else if (|isr)   eoiMask[highestPri(isr)] = 1'b1;
    end
    // A set landing on a bit being cleared in the same cycle takes precedence.
    isrNext = (isr & ~(eoiMask | aeoiMask)) | setMask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      intaNQ    <= 1'b1;
      levelQ    <= '0;
      spuriousQ <= 1'b0;
      intOut    <= 1'b0;
      clearIRR  <= 1'b0;
      resetIRR  <= '0;
      isr       <= '0;
      dataOut   <= '0;
      dataOutEn <= 1'b0;
    end else begin
      intaNQ   <= intaN;
      clearIRR <= 1'b0;
      isr      <= isrNext;
      unique case (state)
        StIdle: begin
          if (candValid) begin
            intOut <= 1'b1;
            state  <= StReq;
          end
        end
        StReq: begin
          if (fall) begin
            // A request that vanished before INTA #1 resolves as spurious.
            levelQ    <= candValid ? candLevel : SpuriousLevel;
            spuriousQ <= ~candValid;
            if (candValid) begin
              clearIRR <= 1'b1;
              resetIRR <= candLevel;
            end
            intOut <= 1'b0;
            state  <= StWait2;
          end
        end
        StWait2: begin
          if (fall) begin
            dataOut   <= {vectorBase, levelQ};
            dataOutEn <= 1'b1;
            state     <= StAck2;
          end
        end
        StAck2: begin
          if (rise) begin
            dataOutEn <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
